// File: rtl/quotient_otf_converter_div.sv
// rtl/quotient_otf_converter_div.sv - on-the-fly conversion of signed quotient digits to a two's-complement quotient
module quotient_otf_converter_div #(
  parameter int Q_DIGITS  = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 async_clear,
  input  logic                 start,
  input  logic                 en_q,
  input  logic [1:0]           q_value,
  input  logic                 quotient_ack,
  output logic [Q_DIGITS:0]    quotient_out,
  output logic                 quotient_valid,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] digit_count
);

  localparam int W = Q_DIGITS + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(Q_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [W-1:0]         q_reg;
  logic [W-1:0]         qm_reg;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 dig_pos;
  logic                 dig_neg;
  logic [W-1:0]         q_nxt;
  logic [W-1:0]         qm_nxt;
  logic                 last_digit;

  // Decode the {plus,minus} digit; 00 and 11 both mean zero.
  always_comb begin
    dig_pos = (q_value == 2'b10);
    dig_neg = (q_value == 2'b01);
  end

  // On-the-fly append: Q and QM=Q-1 are both extended so that no carry chain is needed.
  always_comb begin
    q_nxt  = q_reg;
    qm_nxt = qm_reg;
    if (dig_pos) begin
      q_nxt  = (q_reg << 1) | W'(1);
      qm_nxt = (q_reg << 1);
    end else if (dig_neg) begin
      q_nxt  = (qm_reg << 1) | W'(1);
      qm_nxt = (qm_reg << 1);
    end else begin
      q_nxt  = (q_reg << 1);
      qm_nxt = (qm_reg << 1) | W'(1);
    end
  end

  // The final digit of a division is the one consumed while the count sits at Q_DIGITS-1.
  always_comb begin
    last_digit = en_q && (cnt == LAST_IDX);
  end

  // Division framing FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (async_clear) begin
      state          <= S_IDLE;
      q_reg          <= '0;
      qm_reg         <= '1;
      cnt            <= '0;
      quotient_out   <= '0;
      quotient_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ACCUM;
            q_reg  <= '0;
            qm_reg <= '1;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        S_ACCUM: begin
          // start is deliberately ignored here: a division runs to completion.
          if (en_q) begin
            q_reg  <= q_nxt;
            qm_reg <= qm_nxt;
            cnt    <= cnt + CNT_WIDTH'(1);
            if (last_digit) begin
              // Publish the result only on completion so it stays put in IDLE
              // and through the next division until that one finishes.
              quotient_out   <= q_nxt;
              state          <= S_DONE;
              busy           <= 1'b0;
              quotient_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            // A new start doubles as the acknowledge for the held result.
            state          <= S_ACCUM;
            q_reg          <= '0;
            qm_reg         <= '1;
            cnt            <= '0;
            busy           <= 1'b1;
            quotient_valid <= 1'b0;
          end else if (quotient_ack) begin
            state          <= S_IDLE;
            quotient_valid <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          busy           <= 1'b0;
          quotient_valid <= 1'b0;
        end
      endcase
    end
  end

  assign digit_count = cnt;

endmodule

// File: tb/tb_quotient_otf_converter_div.sv
// tb/tb_quotient_otf_converter_div.sv - randomized and directed checks of the quotient converter against an arithmetic model
module tb_quotient_otf_converter_div;

  localparam int QD = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          async_clear;
  logic          start;
  logic          en_q;
  logic [1:0]    q_value;
  logic          quotient_ack;
  logic [QD:0]   quotient_out;
  logic          quotient_valid;
  logic          busy;
  logic [CW-1:0] digit_count;

  int vectors = 0;
  int fails   = 0;

  // Arithmetic reference: the quotient is the plain weighted sum of digits.
  int     m_phase = 0;   // 0 idle, 1 accumulating, 2 holding result
  longint m_acc   = 0;
  int     m_cnt   = 0;
  longint m_out   = 0;
  bit     m_live  = 0;

  quotient_otf_converter_div #(.Q_DIGITS(QD), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .async_clear    (async_clear),
    .start          (start),
    .en_q           (en_q),
    .q_value        (q_value),
    .quotient_ack   (quotient_ack),
    .quotient_out   (quotient_out),
    .quotient_valid (quotient_valid),
    .busy           (busy),
    .digit_count    (digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint digit_val(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (async_clear) begin
      m_phase = 0; m_acc = 0; m_cnt = 0; m_out = 0; m_live = 1;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_acc = 0; m_cnt = 0; end
        1: if (en_q) begin
             m_acc = m_acc * 2 + digit_val(q_value);
             m_cnt++;
             if (m_cnt == QD) begin m_out = m_acc; m_phase = 2; end
           end
        default: if (start) begin m_phase = 1; m_acc = 0; m_cnt = 0; end
                 else if (quotient_ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", {63'b0, busy}, {63'b0, m_phase == 1});
      chk("quotient_valid", {63'b0, quotient_valid}, {63'b0, m_phase == 2});
      chk("digit_count", {59'b0, digit_count}, 64'(m_cnt));
      chk("quotient_out", 64'($signed(quotient_out)), 64'(m_out));
    end
  end

  task automatic do_div(input logic [7:0] digs, input int gap, input bit mid_start,
                        input logic [QD:0] exp, input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < QD; i++) begin
      en_q    = 1'b1;
      q_value = digs[7-2*i -: 2];
      start   = (mid_start && i == 1);
      if (gap > 0 && i > 0) chk({name, "_cnt_gap"}, {59'b0, digit_count}, 64'(i));
      @(negedge clk);
      en_q  = 1'b0;
      start = 1'b0;
      repeat (gap) @(negedge clk);
    end
    if (gap > 0) begin
      chk({name, "_valid"}, {63'b0, quotient_valid}, 64'(1));
    end else begin
      chk({name, "_valid"}, {63'b0, quotient_valid}, 64'(1));
      chk({name, "_out"}, {59'b0, quotient_out}, {59'b0, exp});
    end
    chk({name, "_value"}, {59'b0, quotient_out}, {59'b0, exp});
  endtask

  task automatic ack_result();
    quotient_ack = 1'b1;
    @(negedge clk);
    quotient_ack = 1'b0;
    chk("ack_drops_valid", {63'b0, quotient_valid}, 64'(0));
  endtask

  initial begin
    async_clear = 1'b1; start = 1'b0; en_q = 1'b0; q_value = 2'b00; quotient_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out", {59'b0, quotient_out}, 64'(0));
    chk("reset_valid", {63'b0, quotient_valid}, 64'(0));
    chk("reset_busy", {63'b0, busy}, 64'(0));
    chk("reset_cnt", {59'b0, digit_count}, 64'(0));
    async_clear = 1'b0;
    @(negedge clk);

    do_div(8'b10_00_01_10, 0, 0, 5'b00111, "p0m_p"); ack_result();
    chk("idle_holds_out", {59'b0, quotient_out}, 64'(5'b00111));
    do_div(8'b01_10_10_10, 0, 0, 5'b11111, "m_ppp"); ack_result();
    do_div(8'b01_01_01_01, 0, 0, 5'b10001, "mmmm"); ack_result();
    do_div(8'b00_00_00_00, 0, 0, 5'b00000, "zero"); ack_result();
    do_div(8'b10_10_10_10, 2, 0, 5'b01111, "gapped");
    chk("gapped_cnt_done", {59'b0, digit_count}, 64'(4));
    ack_result();
    do_div(8'b10_11_10_00, 0, 1, 5'b01010, "digit11_midstart");

    // Hold in DONE with stray digits, then restart without ack.
    for (int k = 0; k < 5; k++) begin
      en_q = 1'b1; q_value = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("done_hold_out", {59'b0, quotient_out}, 64'(5'b01010));
      chk("done_hold_valid", {63'b0, quotient_valid}, 64'(1));
    end
    en_q = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", {63'b0, quotient_valid}, 64'(0));
    chk("restart_cnt", {59'b0, digit_count}, 64'(0));
    chk("restart_busy", {63'b0, busy}, 64'(1));
    for (int i = 0; i < QD; i++) begin
      en_q = 1'b1; q_value = 2'b10;
      @(negedge clk);
    end
    en_q = 1'b0;
    chk("restart_out", {59'b0, quotient_out}, 64'(5'b01111));
    ack_result();

    // Abort a division with reset after two digits.
    start = 1'b1; @(negedge clk); start = 1'b0;
    en_q = 1'b1; q_value = 2'b01; @(negedge clk);
    q_value = 2'b01; @(negedge clk);
    en_q = 1'b0; async_clear = 1'b1; start = 1'b1; quotient_ack = 1'b1;
    @(negedge clk);
    async_clear = 1'b0; start = 1'b0; quotient_ack = 1'b0;
    chk("abort_out", {59'b0, quotient_out}, 64'(0));
    chk("abort_busy", {63'b0, busy}, 64'(0));
    chk("abort_valid", {63'b0, quotient_valid}, 64'(0));
    chk("abort_cnt", {59'b0, digit_count}, 64'(0));
    do_div(8'b10_00_00_10, 0, 0, 5'b01001, "after_abort"); ack_result();

    // Randomized traffic; the per-cycle compare process checks against the model.
    for (int n = 0; n < 3000; n++) begin
      async_clear  = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 7) == 0);
      en_q         = ($urandom_range(0, 2) != 0);
      q_value      = 2'($urandom_range(0, 3));
      quotient_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    async_clear = 1'b0; start = 1'b0; en_q = 1'b0; quotient_ack = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/quotient_otf_converter_div.md
# quotient_otf_converter_div

Downstream of the v-value/quotient-selection stage in the digit-serial divider. Consumes one signed quotient digit per enabled cycle from `q_value` and converts the redundant digit stream to a conventional two's-complement quotient with on-the-fly conversion, so no final carry-propagate add is needed. A small FSM frames each division. It holds the finished quotient until the consumer acknowledges it.

## Interface
Parameters:
- `Q_DIGITS`, 16: quotient digits per division, ≥2.
- `CNT_WIDTH`, 5: digit counter width, ≥ clog2(Q_DIGITS+1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `async_clear`  in  1  reset; synchronous, active-high, sampled on rising `clk`.
- `start`  in  1  begin a new division; honoured in IDLE and DONE only.
- `en_q`  in  1  `q_value` holds a valid digit this cycle.
- `q_value`  in  2  signed digit {plus,minus}: 10 = +1, 01 = −1, 00 = 0, 11 = 0.
- `quotient_ack`  in  1  consumer has taken `quotient_out`.
- `quotient_out`  out  Q_DIGITS+1  two's-complement quotient; MSD weight 2^(Q_DIGITS−1).
- `quotient_valid`  out  1  high in DONE.
- `busy`  out  1  high in ACCUM.
- `digit_count`  out  CNT_WIDTH  digits consumed in the current division.

## Operation
- Registers: `Q` and `QM` (each Q_DIGITS+1 bits, invariant QM = Q − 1), `cnt`, 2-bit state.
- States: IDLE, ACCUM, DONE.
- IDLE → ACCUM on `start`. Load Q = 0, QM = all ones (−1), cnt = 0.
- ACCUM, `en_q`=1, digit d:
  - d=+1: Q ← {Q,1}; QM ← {Q,0}.
  - d=0: Q ← {Q,0}; QM ← {QM,1}.
  - d=−1: Q ← {QM,1}; QM ← {QM,0}.
  - Shifts are left by one and keep the low Q_DIGITS+1 bits. cnt ← cnt+1.
- ACCUM, `en_q`=0: all registers hold; no timeout.
- ACCUM → DONE when the digit at cnt = Q_DIGITS−1 is consumed.
- DONE: `quotient_out` = Q, held stable. `en_q` is ignored.
- DONE → IDLE on `quotient_ack`.
- DONE with `start` (with or without ack): acts as an implicit ack and enters ACCUM with a fresh load.
- `start` in ACCUM is ignored. A division cannot be aborted except by reset.
- Digit 11 is treated as 0 and is counted.
- Range: ±(2^Q_DIGITS − 1) fits in Q_DIGITS+1 bits, so no overflow is possible.

## Timing
- Reset (synchronous, any state, including mid-division) → next edge: state = IDLE, Q = 0, QM = all ones, cnt = 0, `quotient_out` = 0, `quotient_valid` = 0, `busy` = 0, `digit_count` = 0. Reset overrides `start`, `en_q` and `quotient_ack` in the same cycle.
- All outputs are registered or decoded from state only. There are no combinational input→output paths.
- `start` at edge t → `busy` = 1 from t+1. The first digit can be accepted at edge t+1.
- The digit accepted at edge t is reflected in `digit_count` at t+1.
- Last digit at edge t → `quotient_valid` = 1 and `quotient_out` = final value from t+1.
- Back-to-back operation: Q_DIGITS consecutive `en_q` cycles give `quotient_valid` exactly Q_DIGITS cycles after the first accepted digit.
- `quotient_ack` at edge t in DONE → `quotient_valid` = 0 at t+1.
- `quotient_out` retains its last value in IDLE. It changes only during ACCUM or on reset.

## Test plan
- Q_DIGITS=4. Reset, start, digits +1,0,−1,+1 on consecutive cycles → `quotient_valid` one cycle after the 4th digit, `quotient_out` = 5'b00111 (7).
- Digits −1,+1,+1,+1 → 5'b11111 (−1). Digits −1,−1,−1,−1 → 5'b10001 (−15). Digits 0,0,0,0 → 0.
- Gapped `en_q` (digit, 2 idle cycles, digit, …) with +1,+1,+1,+1 → 01111. `digit_count` steps 0→1→2→3, holds during gaps, then reaches 4 in DONE.
- Digit 11 injected at position 2 of +1,11,+1,0 → same result as +1,0,+1,0 = 01010. `start` pulsed mid-ACCUM → ignored, result unchanged.
- DONE held 5 cycles without ack → `quotient_out` stable, extra `en_q` ignored. `start` in DONE → new division; `quotient_valid` drops next cycle, `digit_count` = 0.
- Assert `async_clear` after 2 digits → next cycle all outputs = 0 and state = IDLE. A following start plus 4 digits gives the correct fresh result with no residue of the aborted division.
